// File: rtl/cpu_defs.sv
// Shared CPU constants for the fetch stage: trap vectors, kernel-mode bit and
// the next-PC source encoding.
package cpu_defs;

    localparam logic [31:0] RESET_VEC  = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC    = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC    = 32'h8000_0008;
    localparam int          KERNEL_BIT = 31;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_EXC,
        SRC_HOLD,
        SRC_JR,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_IRQ
    } pc_src_e;

    // Sequential increment wraps inside the low 31 bits so it can never enter kernel mode.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return {pc[KERNEL_BIT], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bundle of control, instruction-memory and IF/ID signals around the fetch stage.
interface fetch_pc_unit_if;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        irq;
    logic        illegal_op;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] epc;
    logic        epc_we;

    // Master: hazard/decode control plus instruction memory; slave: the fetch unit.
    modport master (
        output stall, branch_taken, branch_target, jump, jump_index,
               jr, jr_target, irq, illegal_op, instr_in,
        input  instr_addr, id_instr, id_pc_plus4, id_valid, epc, epc_we
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_index,
               jr, jr_target, irq, illegal_op, instr_in,
        output instr_addr, id_instr, id_pc_plus4, id_valid, epc, epc_we
    );

endinterface

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register: captures instruction and PC+4, holds on stall,
// and turns into a bubble on flush.
module if_id_reg
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path can infer a latch.
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            instr_q    <= NOP;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign id_instr    = instr_q;
    assign id_pc_plus4 = pc_plus4_q;
    assign id_valid    = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter with trap/redirect selection feeding InstructionMemory, plus
// the IF/ID register and the EPC ($k0) write port.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VEC = cpu_defs::RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = cpu_defs::IRQ_VEC,
    parameter logic [31:0] EXC_VEC   = cpu_defs::EXC_VEC
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.slave  bus
);

    import cpu_defs::*;

    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        epc_we_q, epc_we_d;
    logic [31:0] pc_seq;
    logic        take_exc, take_irq;
    logic        if_load, if_flush;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    pc_src_e     src;

    // Exceptions outrank stall; in kernel mode both traps are masked (irq stays pending).
    always_comb begin
        pc_seq   = pc_incr(pc_q);
        take_exc = bus.illegal_op & id_valid & ~pc_q[KERNEL_BIT];
        take_irq = bus.irq & ~pc_q[KERNEL_BIT];
        if (take_exc)              src = SRC_EXC;
        else if (bus.stall)        src = SRC_HOLD;
        else if (bus.jr)           src = SRC_JR;
        else if (bus.jump)         src = SRC_JUMP;
        else if (bus.branch_taken) src = SRC_BRANCH;
        else if (take_irq)         src = SRC_IRQ;
        else                       src = SRC_SEQ;
    end

    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        epc_we_d = 1'b0;
        if_load  = 1'b0;
        if_flush = 1'b0;
        case (src)
            SRC_EXC: begin
                pc_d     = EXC_VEC;
                epc_d    = id_pc_plus4;
                epc_we_d = 1'b1;
                if_flush = 1'b1;
            end
            SRC_JR: begin
                pc_d     = bus.jr_target;
                if_flush = 1'b1;
            end
            SRC_JUMP: begin
                pc_d     = {pc_q[KERNEL_BIT], id_pc_plus4[30:28], bus.jump_index, 2'b00};
                if_flush = 1'b1;
            end
            SRC_BRANCH: begin
                pc_d     = {pc_q[KERNEL_BIT], bus.branch_target[30:0]};
                if_flush = 1'b1;
            end
            SRC_IRQ: begin
                // The fetched instruction is squashed, so return re-fetches from the current pc.
                pc_d     = IRQ_VEC;
                epc_d    = pc_q;
                epc_we_d = 1'b1;
                if_flush = 1'b1;
            end
            SRC_SEQ: begin
                pc_d    = pc_seq;
                if_load = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_VEC;
            epc_q    <= 32'h0;
            epc_we_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            epc_we_q <= epc_we_d;
        end
    end

    if_id_reg u_if_id (
        .clk         (clk),
        .reset       (reset),
        .load        (if_load),
        .flush       (if_flush),
        .instr_in    (bus.instr_in),
        .pc_plus4_in (pc_seq),
        .id_instr    (bus.id_instr),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid)
    );

    assign bus.instr_addr  = pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4;
    assign bus.id_valid    = id_valid;
    assign bus.epc         = epc_q;
    assign bus.epc_we      = epc_we_q;

    redirect_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({bus.jr, bus.jump, bus.branch_taken}));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expected outputs are queued with each step
// and checked just after the following clock edge.
module tb_fetch_pc_unit;

    import cpu_defs::*;

    typedef enum int {O_PC, O_VALID, O_INSTR, O_PC4, O_EPC, O_EPC_WE} obs_e;
    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic clk = 1'b0;
    logic reset;

    fetch_pc_unit_if bus();

    fetch_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign bus.instr_in = imem(bus.instr_addr);

    function automatic logic [31:0] observe(input obs_e s);
        case (s)
            O_PC:     return bus.instr_addr;
            O_VALID:  return {31'b0, bus.id_valid};
            O_INSTR:  return bus.id_instr;
            O_PC4:    return bus.id_pc_plus4;
            O_EPC:    return bus.epc;
            O_EPC_WE: return {31'b0, bus.epc_we};
            default:  return 32'hXXXX_XXXX;
        endcase
    endfunction

    task automatic want(input string tag, input obs_e sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_index    = 26'h0;
        bus.jr            = 1'b0;
        bus.jr_target     = 32'h0;
        bus.irq           = 1'b0;
        bus.illegal_op    = 1'b0;
    endtask

    task automatic do_jr(input string tag, input logic [31:0] t);
        bus.jr = 1'b1; bus.jr_target = t;
        want(tag, O_PC, t);
        want(tag, O_VALID, 32'd0);
        tick(); idle();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle();
        want("rst_pc", O_PC, RESET_VEC);
        want("rst_valid", O_VALID, 32'd0);
        want("rst_instr", O_INSTR, 32'h0);
        want("rst_pc4", O_PC4, 32'h0);
        want("rst_epc", O_EPC, 32'h0);
        want("rst_epc_we", O_EPC_WE, 32'd0);
        tick();
        reset = 1'b0;

        // Free-running fetch from the reset vector, then a kernel jump.
        want("seq1_pc", O_PC, 32'h8000_0004);
        want("seq1_valid", O_VALID, 32'd1);
        want("seq1_instr", O_INSTR, imem(32'h8000_0000));
        want("seq1_pc4", O_PC4, 32'h8000_0004);
        tick();
        want("seq2_pc", O_PC, 32'h8000_0008);
        want("seq2_instr", O_INSTR, imem(32'h8000_0004));
        tick();
        bus.jump = 1'b1; bus.jump_index = 26'd3;
        want("jmp_pc", O_PC, 32'h8000_000C);
        want("jmp_bubble", O_VALID, 32'd0);
        tick(); idle();
        want("jmp_next_pc", O_PC, 32'h8000_0010);
        want("jmp_next_valid", O_VALID, 32'd1);
        want("jmp_next_instr", O_INSTR, imem(32'h8000_000C));
        want("jmp_next_pc4", O_PC4, 32'h8000_0010);
        tick();

        // User-mode interrupt.
        do_jr("jr_user_pc", 32'h0000_0100);
        bus.irq = 1'b1;
        want("irq_pc", O_PC, IRQ_VEC);
        want("irq_epc", O_EPC, 32'h0000_0100);
        want("irq_epc_we", O_EPC_WE, 32'd1);
        want("irq_valid", O_VALID, 32'd0);
        tick(); idle();
        want("irq_after_pc", O_PC, 32'h8000_0008);
        want("irq_after_we", O_EPC_WE, 32'd0);
        want("irq_after_epc", O_EPC, 32'h0000_0100);
        want("irq_after_instr", O_INSTR, imem(32'h8000_0004));
        tick();

        // Undefined instruction in user mode.
        do_jr("jr_200_pc", 32'h0000_0200);
        want("pre_exc_pc", O_PC, 32'h0000_0204);
        want("pre_exc_pc4", O_PC4, 32'h0000_0204);
        want("pre_exc_valid", O_VALID, 32'd1);
        tick();
        bus.illegal_op = 1'b1;
        want("exc_pc", O_PC, EXC_VEC);
        want("exc_epc", O_EPC, 32'h0000_0204);
        want("exc_epc_we", O_EPC_WE, 32'd1);
        want("exc_valid", O_VALID, 32'd0);
        want("exc_instr", O_INSTR, NOP);
        tick(); idle();
        want("exc_after_we", O_EPC_WE, 32'd0);
        want("exc_after_pc", O_PC, 32'h8000_000C);
        want("exc_after_epc", O_EPC, 32'h0000_0204);
        tick();

        // Undefined instruction in kernel mode runs as a nop.
        bus.illegal_op = 1'b1;
        want("kexc_pc", O_PC, 32'h8000_0010);
        want("kexc_we", O_EPC_WE, 32'd0);
        want("kexc_epc", O_EPC, 32'h0000_0204);
        want("kexc_valid", O_VALID, 32'd1);
        tick(); idle();

        // irq held in kernel mode, still deferred under a redirect, taken in user mode.
        do_jr("jr_k50_pc", 32'h8000_0050);
        bus.irq = 1'b1;
        want("kirq_pc", O_PC, 32'h8000_0054);
        want("kirq_we", O_EPC_WE, 32'd0);
        want("kirq_valid", O_VALID, 32'd1);
        tick();
        bus.jr = 1'b1; bus.jr_target = 32'h0000_0100;
        want("jr_irq_pc", O_PC, 32'h0000_0100);
        want("jr_irq_we", O_EPC_WE, 32'd0);
        want("jr_irq_epc", O_EPC, 32'h0000_0204);
        tick();
        bus.jr = 1'b0; bus.jr_target = 32'h0;
        want("defer_irq_pc", O_PC, IRQ_VEC);
        want("defer_irq_epc", O_EPC, 32'h0000_0100);
        want("defer_irq_we", O_EPC_WE, 32'd1);
        want("defer_irq_valid", O_VALID, 32'd0);
        tick(); idle();

        // Stall masks a branch and an interrupt; the branch lands once released.
        do_jr("jr_300_pc", 32'h0000_0300);
        want("pre_stall_pc", O_PC, 32'h0000_0304);
        want("pre_stall_instr", O_INSTR, imem(32'h0000_0300));
        tick();
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0040; bus.irq = 1'b1;
        want("stall_pc", O_PC, 32'h0000_0304);
        want("stall_instr", O_INSTR, imem(32'h0000_0300));
        want("stall_pc4", O_PC4, 32'h0000_0304);
        want("stall_valid", O_VALID, 32'd1);
        want("stall_we", O_EPC_WE, 32'd0);
        tick();
        bus.stall = 1'b0;
        want("br_pc", O_PC, 32'h0000_0040);
        want("br_bubble", O_VALID, 32'd0);
        want("br_we", O_EPC_WE, 32'd0);
        tick(); idle();
        want("br_next_pc", O_PC, 32'h0000_0044);
        want("br_next_valid", O_VALID, 32'd1);
        want("br_next_instr", O_INSTR, imem(32'h0000_0040));
        tick();

        // Kernel bit survives jump and branch.
        do_jr("jr_ke8_pc", 32'h8000_00E8);
        want("ke8_seq_pc", O_PC, 32'h8000_00EC);
        want("ke8_seq_pc4", O_PC4, 32'h8000_00EC);
        tick();
        bus.jump = 1'b1; bus.jump_index = 26'h000_0040;
        want("kjmp_pc", O_PC, 32'h8000_0100);
        tick(); idle();
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0040;
        want("kbr_pc", O_PC, 32'h8000_0040);
        tick(); idle();

        // Increment wraps inside 31 bits.
        do_jr("jr_top_pc", 32'hFFFF_FFFC);
        want("wrap_pc", O_PC, 32'h8000_0000);
        want("wrap_pc4", O_PC4, 32'h8000_0000);
        want("wrap_valid", O_VALID, 32'd1);
        tick();

        // Reset beats a pending trap during stall.
        do_jr("jr_500_pc", 32'h0000_0500);
        bus.stall = 1'b1; bus.irq = 1'b1; reset = 1'b1;
        want("rst2_pc", O_PC, RESET_VEC);
        want("rst2_we", O_EPC_WE, 32'd0);
        want("rst2_epc", O_EPC, 32'h0);
        want("rst2_valid", O_VALID, 32'd0);
        tick(); idle();
        reset = 1'b0;
        want("rst2_next_pc", O_PC, 32'h8000_0004);
        want("rst2_next_valid", O_VALID, 32'd1);
        want("rst2_next_instr", O_INSTR, imem(32'h8000_0000));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
